// File: rtl/instr_issuer_pkg.sv
// Shared definitions for the systolic-array instruction word: opcodes, field positions,
// issuer FSM states and the instruction packing helpers.
package instr_issuer_pkg;

    localparam int INSTR_W  = 64;
    localparam int OPC_MSB  = 63;
    localparam int OPC_LSB  = 59;
    localparam int ADDR_MSB = 58;
    localparam int ADDR_LSB = 43;
    localparam int DATA_MSB = 42;
    localparam int DATA_LSB = 27;

    localparam logic [4:0] OP_NONE      = 5'b00000;
    localparam logic [4:0] OP_MAC       = 5'b00001;
    localparam logic [4:0] OP_SEND_WT   = 5'b00010;
    localparam logic [4:0] OP_STORE_OUT = 5'b00011;
    localparam logic [4:0] OP_RECV_INP  = 5'b00100;
    localparam logic [4:0] OP_RECV_WT   = 5'b00101;
    localparam logic [4:0] OP_XMIT_OUT  = 5'b00110;
    localparam logic [4:0] OP_ACC_COPY  = 5'b00111;
    localparam logic [4:0] OP_NOP       = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_DAT = 2'd2,
        ST_GAP      = 2'd3
    } issuer_state_e;

    // Bits below DATA_LSB are reserved and always zero.
    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic [4:0]  op,
        input logic [15:0] addr,
        input logic [15:0] data
    );
        logic [INSTR_W-1:0] w;
        w = 64'h0;
        w[OPC_MSB:OPC_LSB]   = op;
        w[ADDR_MSB:ADDR_LSB] = addr;
        w[DATA_MSB:DATA_LSB] = data;
        return w;
    endfunction

    function automatic logic is_load_op(input logic [4:0] op);
        return (op == OP_RECV_INP) || (op == OP_RECV_WT);
    endfunction

endpackage

// File: rtl/instr_issuer.sv
// Burst-command expander: turns each accepted command into a run of 64-bit instructions with
// auto-incremented address, merging streamed data words for the buffer-load opcodes.
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int LEN_W     = 8,
    parameter int STORE_GAP = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [4:0]          cmd_opcode,
    input  logic [15:0]         cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                dat_valid,
    output logic                dat_ready,
    input  logic [15:0]         dat_word,
    output logic [INSTR_W-1:0]  instruction,
    output logic                busy
);

    localparam int GAP_W = (STORE_GAP < 2) ? 1 : $clog2(STORE_GAP + 1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(STORE_GAP);
    localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);

    issuer_state_e         state_r;
    logic [4:0]            op_r;
    logic [15:0]           addr_r;
    logic [LEN_W-1:0]      remaining_r;
    logic [GAP_W-1:0]      gap_cnt_r;
    logic [INSTR_W-1:0]    instruction_r;
    logic                  cmd_ready_r;
    logic                  dat_ready_r;
    logic                  busy_r;

    // Issuer FSM: every output is a register updated together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            op_r          <= OP_NONE;
            addr_r        <= 16'h0;
            remaining_r   <= LEN_ZERO;
            gap_cnt_r     <= GAP_ZERO;
            instruction_r <= 64'h0;
            cmd_ready_r   <= 1'b0;
            dat_ready_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    instruction_r <= 64'h0;
                    dat_ready_r   <= 1'b0;
                    if (cmd_valid && cmd_ready_r) begin
                        op_r        <= cmd_opcode;
                        addr_r      <= cmd_addr;
                        remaining_r <= (cmd_len == LEN_ZERO) ? LEN_ONE : cmd_len;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (is_load_op(cmd_opcode)) begin
                            state_r     <= ST_WAIT_DAT;
                            dat_ready_r <= 1'b1;
                        end else begin
                            state_r <= ST_ISSUE;
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end

                ST_ISSUE: begin
                    instruction_r <= pack_instr(op_r, addr_r, 16'h0);
                    addr_r        <= addr_r + 16'h1;
                    remaining_r   <= remaining_r - LEN_ONE;
                    if (remaining_r == LEN_ONE) begin
                        if ((op_r == OP_STORE_OUT) && (STORE_GAP > 0)) begin
                            state_r   <= ST_GAP;
                            gap_cnt_r <= GAP_INIT;
                        end else begin
                            state_r     <= ST_IDLE;
                            cmd_ready_r <= 1'b1;
                            busy_r      <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end

                ST_WAIT_DAT: begin
                    if (dat_valid && dat_ready_r) begin
                        instruction_r <= pack_instr(op_r, addr_r, dat_word);
                        addr_r        <= addr_r + 16'h1;
                        remaining_r   <= remaining_r - LEN_ONE;
                        if (remaining_r == LEN_ONE) begin
                            state_r     <= ST_IDLE;
                            dat_ready_r <= 1'b0;
                            cmd_ready_r <= 1'b1;
                            busy_r      <= 1'b0;
                        end else begin
                            state_r <= ST_WAIT_DAT;
                        end
                    end else begin
                        instruction_r <= 64'h0;
                    end
                end

                // The store word itself is presented while already in GAP, so the counter
                // starts at STORE_GAP to give that many zero words with cmd_ready still low.
                ST_GAP: begin
                    instruction_r <= 64'h0;
                    if (gap_cnt_r == GAP_ZERO) begin
                        state_r     <= ST_IDLE;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - GAP_W'(1);
                    end
                end

                default: begin
                    state_r       <= ST_IDLE;
                    instruction_r <= 64'h0;
                    cmd_ready_r   <= 1'b0;
                    dat_ready_r   <= 1'b0;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign instruction = instruction_r;
    assign cmd_ready   = cmd_ready_r;
    assign dat_ready   = dat_ready_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed self-checking bench for instr_issuer: reset, MAC, stalled load, store gap,
// address wrap / zero length and mid-burst reset.
module tb_instr_issuer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_opcode;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        dat_valid;
    logic        dat_ready;
    logic [15:0] dat_word;
    logic [63:0] instruction;
    logic        busy;

    int total;
    int bad;

    instr_issuer #(.LEN_W(8), .STORE_GAP(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .dat_valid   (dat_valid),
        .dat_ready   (dat_ready),
        .dat_word    (dat_word),
        .instruction (instruction),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] mk(input logic [4:0] op, input logic [15:0] a,
                                       input logic [15:0] d);
        return {op, a, d, 27'h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [4:0] op, input logic [15:0] a, input logic [7:0] len);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_addr   = a;
        cmd_len    = len;
        tick();
        cmd_valid  = 1'b0;
    endtask

    logic [15:0] load_data [4];

    initial begin
        total = 0;
        bad   = 0;
        load_data[0] = 16'h00A1;
        load_data[1] = 16'h00B2;
        load_data[2] = 16'h00C3;
        load_data[3] = 16'h00D4;

        // 1: reset with random inputs
        rst_n      = 1'b0;
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_opcode = 5'($urandom);
        cmd_addr   = 16'($urandom);
        cmd_len    = 8'($urandom);
        dat_valid  = 1'($urandom_range(0, 1));
        dat_word   = 16'($urandom);
        tick();
        tick();
        tick();
        chk("rst_instr", instruction, 64'h0);
        chk("rst_cmd_ready", {63'h0, cmd_ready}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_dat_ready", {63'h0, dat_ready}, 64'h0);
        cmd_valid = 1'b0;
        dat_valid = 1'b0;
        rst_n     = 1'b1;
        tick();
        chk("rel_cmd_ready", {63'h0, cmd_ready}, 64'h1);
        chk("rel_instr", instruction, 64'h0);

        // 2: MAC burst of 3
        send_cmd(5'b00001, 16'h0010, 8'd3);
        chk("mac_hs_instr", instruction, 64'h0);
        chk("mac_hs_busy", {63'h0, busy}, 64'h1);
        chk("mac_hs_cmd_ready", {63'h0, cmd_ready}, 64'h0);
        tick();
        chk("mac_w0_const", instruction, 64'h0800_8000_0000_0000);
        tick();
        chk("mac_w1", instruction, mk(5'b00001, 16'h0011, 16'h0000));
        tick();
        chk("mac_w2", instruction, mk(5'b00001, 16'h0012, 16'h0000));
        tick();
        chk("mac_end_instr", instruction, 64'h0);
        chk("mac_end_cmd_ready", {63'h0, cmd_ready}, 64'h1);
        chk("mac_end_busy", {63'h0, busy}, 64'h0);

        // 3: load burst with a stall every other cycle
        send_cmd(5'b00100, 16'h0100, 8'd4);
        chk("ld_hs_instr", instruction, 64'h0);
        chk("ld_hs_dat_ready", {63'h0, dat_ready}, 64'h1);
        for (int i = 0; i < 8; i++) begin
            dat_valid = (i % 2 == 0);
            dat_word  = load_data[i / 2];
            tick();
            if (i % 2 == 0)
                chk("ld_word", instruction, mk(5'b00100, 16'h0100 + 16'(i / 2), load_data[i / 2]));
            else
                chk("ld_stall", instruction, 64'h0);
        end
        dat_valid = 1'b0;
        chk("ld_end_dat_ready", {63'h0, dat_ready}, 64'h0);
        chk("ld_end_cmd_ready", {63'h0, cmd_ready}, 64'h1);

        // 4: store with two-cycle gap
        send_cmd(5'b00011, 16'h0005, 8'd1);
        tick();
        chk("st_word", instruction, mk(5'b00011, 16'h0005, 16'h0000));
        chk("st_word_cmd_ready", {63'h0, cmd_ready}, 64'h0);
        tick();
        chk("st_gap1_instr", instruction, 64'h0);
        chk("st_gap1_cmd_ready", {63'h0, cmd_ready}, 64'h0);
        tick();
        chk("st_gap2_instr", instruction, 64'h0);
        chk("st_gap2_cmd_ready", {63'h0, cmd_ready}, 64'h0);
        tick();
        chk("st_done_instr", instruction, 64'h0);
        chk("st_done_cmd_ready", {63'h0, cmd_ready}, 64'h1);

        // 5: address wrap; stray data must be ignored
        dat_valid = 1'b1;
        dat_word  = 16'hBEEF;
        send_cmd(5'b00010, 16'hFFFF, 8'd2);
        chk("wr_dat_ready", {63'h0, dat_ready}, 64'h0);
        tick();
        chk("wr_w0", instruction, mk(5'b00010, 16'hFFFF, 16'h0000));
        tick();
        chk("wr_w1", instruction, mk(5'b00010, 16'h0000, 16'h0000));
        tick();
        chk("wr_end", instruction, 64'h0);
        dat_valid = 1'b0;
        // zero length behaves as one
        send_cmd(5'b00010, 16'h0020, 8'd0);
        tick();
        chk("len0_w0", instruction, mk(5'b00010, 16'h0020, 16'h0000));
        tick();
        chk("len0_after", instruction, 64'h0);
        chk("len0_busy", {63'h0, busy}, 64'h0);
        chk("len0_cmd_ready", {63'h0, cmd_ready}, 64'h1);

        // 6: reset during word 2 of a five-word burst
        send_cmd(5'b00001, 16'h0040, 8'd5);
        tick();
        chk("mr_w0", instruction, mk(5'b00001, 16'h0040, 16'h0000));
        tick();
        chk("mr_w1", instruction, mk(5'b00001, 16'h0041, 16'h0000));
        rst_n = 1'b0;
        #1;
        chk("mr_async_instr", instruction, 64'h0);
        chk("mr_async_busy", {63'h0, busy}, 64'h0);
        tick();
        rst_n = 1'b1;
        chk("mr_rel_instr", instruction, 64'h0);
        tick();
        chk("mr_post_instr", instruction, 64'h0);
        chk("mr_post_cmd_ready", {63'h0, cmd_ready}, 64'h1);
        send_cmd(5'b00111, 16'h0300, 8'd1);
        chk("mr_new_hs", instruction, 64'h0);
        tick();
        chk("mr_new_w0", instruction, mk(5'b00111, 16'h0300, 16'h0000));
        tick();
        chk("mr_new_end", instruction, 64'h0);
        tick();
        chk("mr_no_stale", instruction, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
